// File: rtl/imem_loader_if.sv
// Bus bundle for the instruction-memory loader: byte stream in, load status out,
// and the core's fetch port.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              load_done;
    logic              load_err;
    logic              cpu_hold;
    logic [ADDR_W:0]   bytes_written;
    logic [29:0]       fetch_addr;
    logic [31:0]       fetch_data;

    modport master (
        output load_start, load_len, byte_valid, byte_data, fetch_addr,
        input  byte_ready, load_done, load_err, cpu_hold, bytes_written, fetch_data
    );

    modport slave (
        input  load_start, load_len, byte_valid, byte_data, fetch_addr,
        output byte_ready, load_done, load_err, cpu_hold, bytes_written, fetch_data
    );
endinterface

// File: rtl/imem_loader.sv
// Writer side of the little-endian instruction memory: streams a program in byte by
// byte, then releases the core and serves 32-bit fetch words.
module imem_loader #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 6
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [7:0]        mem_q [MEM_BYTES];

    logic              len_ok;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W-3:0] word_a;

    assign len_ok  = (bus.load_len != '0)
                  && (bus.load_len <= (ADDR_W+1)'(MEM_BYTES))
                  && (bus.load_len[1:0] == 2'b00);
    assign cnt_inc = cnt_q + (ADDR_W+1)'(1);
    assign word_a  = bus.fetch_addr[ADDR_W-3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; a reset mid-load leaves bytes behind the NOP mask.
    always_ff @(posedge clk) begin
        if (!rst && state_q == LOAD && bus.byte_valid) begin
            mem_q[cnt_q[ADDR_W-1:0]] <= bus.byte_data;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.load_start) begin
                    if (len_ok) begin
                        state_d = LOAD;
                        len_d   = bus.load_len;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.byte_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready    = (state_q == LOAD);
        bus.load_done     = (state_q == DONE);
        bus.cpu_hold      = (state_q != DONE);
        bus.load_err      = err_q;
        bus.bytes_written = cnt_q;
        if (state_q != DONE) begin
            bus.fetch_data = 32'h0000_0013;
        end else begin
            bus.fetch_data = {mem_q[{word_a, 2'b11}], mem_q[{word_a, 2'b10}],
                              mem_q[{word_a, 2'b01}], mem_q[{word_a, 2'b00}]};
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed program loads plus randomized traffic,
// compared every cycle against a byte-array model of the loader.
module tb_imem_loader;
    localparam int MEM_BYTES = 64;
    localparam int ADDR_W    = 6;
    localparam int WORDS     = MEM_BYTES / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit         m_loading = 1'b0;
    bit         m_done    = 1'b0;
    bit         m_err     = 1'b0;
    int         m_len     = 0;
    int         m_cnt     = 0;
    logic [7:0] m_mem   [MEM_BYTES];
    bit         m_known [MEM_BYTES];
    bit         cmp_en    = 1'b0;
    bit         rnd_fa    = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            m_loading <= 1'b0;
            m_done    <= 1'b0;
            m_err     <= 1'b0;
            m_cnt     <= 0;
        end else if (m_loading) begin
            if (bus.byte_valid) begin
                m_mem[m_cnt]   <= bus.byte_data;
                m_known[m_cnt] <= 1'b1;
                m_cnt          <= m_cnt + 1;
                if (m_cnt + 1 == m_len) begin
                    m_loading <= 1'b0;
                    m_done    <= 1'b1;
                end
            end
        end else if (bus.load_start) begin
            if (bus.load_len != 0 && int'(bus.load_len) <= MEM_BYTES && bus.load_len % 4 == 0) begin
                m_loading <= 1'b1;
                m_done    <= 1'b0;
                m_err     <= 1'b0;
                m_cnt     <= 0;
                m_len     <= int'(bus.load_len);
            end else begin
                m_err  <= 1'b1;
                m_done <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] model_word(input int addr);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) w[b*8 +: 8] = m_mem[(addr % WORDS) * 4 + b];
        return w;
    endfunction

    function automatic logic [31:0] model_mask(input int addr);
        logic [31:0] mk;
        mk = '0;
        for (int b = 0; b < 4; b++) if (m_known[(addr % WORDS) * 4 + b]) mk[b*8 +: 8] = 8'hFF;
        return mk;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] ew, mk;
            chk("byte_ready",    32'(bus.byte_ready),    32'(m_loading));
            chk("load_done",     32'(bus.load_done),     32'(m_done));
            chk("cpu_hold",      32'(bus.cpu_hold),      32'(!m_done));
            chk("load_err",      32'(bus.load_err),      32'(m_err));
            chk("bytes_written", 32'(bus.bytes_written), 32'(m_cnt));
            if (!m_done) begin
                ew = 32'h0000_0013;
                mk = '1;
            end else begin
                ew = model_word(int'(bus.fetch_addr[3:0]));
                mk = model_mask(int'(bus.fetch_addr[3:0]));
            end
            chk("fetch_data", bus.fetch_data & mk, ew & mk);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_fa) bus.fetch_addr = 30'($urandom);
    endtask

    task automatic start(input int len);
        bus.load_start = 1'b1;
        bus.load_len   = (ADDR_W+1)'(len);
        tick();
        bus.load_start = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: valid pattern 1,0,0 repeating, 2: random valid plus stray load_start
    task automatic send(input logic [7:0] data[$], input int n, input int mode);
        int  i, cyc;
        bit  v, hs;
        i = 0;
        cyc = 0;
        while (i < n) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            bus.byte_valid = v;
            bus.byte_data  = v ? data[i] : 8'($urandom);
            if (mode == 2) begin
                bus.load_start = ($urandom_range(0, 7) == 0);
                bus.load_len   = (ADDR_W+1)'($urandom);
            end
            hs = v && bus.byte_ready;
            tick();
            if (hs) i++;
            cyc++;
            if (cyc > 2000) begin
                chk("send_timeout", 32'(i), 32'(n));
                break;
            end
        end
        bus.byte_valid = 1'b0;
        bus.load_start = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    task automatic peek(input string name, input int addr, input logic [31:0] exp);
        bus.fetch_addr = 30'(addr);
        @(negedge clk);
        chk(name, bus.fetch_data, exp);
        #1;
    endtask

    task automatic status(input string name, input bit done, input bit hold, input bit ready,
                          input bit err, input int bw);
        @(negedge clk);
        chk({name, "_done"},  32'(bus.load_done),     32'(done));
        chk({name, "_hold"},  32'(bus.cpu_hold),      32'(hold));
        chk({name, "_ready"}, 32'(bus.byte_ready),    32'(ready));
        chk({name, "_err"},   32'(bus.load_err),      32'(err));
        chk({name, "_bw"},    32'(bus.bytes_written), 32'(bw));
        #1;
    endtask

    logic [7:0] prog8[$] = '{8'hB7, 8'h40, 8'h06, 8'h00, 8'h37, 8'hC1, 8'hF9, 8'hFF};
    logic [7:0] prog4[$] = '{8'h13, 8'h05, 8'hA0, 8'h00};
    logic [7:0] prog4b[$] = '{8'h93, 8'h00, 8'h10, 8'h00};

    initial begin
        logic [7:0] q[$];
        int len, n;
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        bus.fetch_addr = '0;

        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        rnd_fa = 1'b0;
        status("reset", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        for (int a = 0; a < 20; a += 5) peek("reset_nop", a, 32'h0000_0013);
        rst = 1'b0;
        tick();

        // Plain 8-byte program
        start(8);
        send(prog8, 8, 0);
        status("load8", 1'b1, 1'b0, 1'b0, 1'b0, 8);
        peek("load8_w0", 0, 32'h000640B7);
        peek("load8_w1", 1, 32'hFFF9C137);
        chk("model_w0", model_word(0), 32'h000640B7);
        chk("model_w1", model_word(1), 32'hFFF9C137);

        // Same stream with gapped valid and garbage data
        start(8);
        send(prog8, 8, 1);
        status("gap8", 1'b1, 1'b0, 1'b0, 1'b0, 8);
        peek("gap8_w0", 0, 32'h000640B7);
        peek("gap8_w1", 1, 32'hFFF9C137);

        // Rejected lengths, then an accepted one
        start(6);
        status("rej6", 1'b0, 1'b1, 1'b0, 1'b1, 8);
        start(68);
        status("rej68", 1'b0, 1'b1, 1'b0, 1'b1, 8);
        start(0);
        status("rej0", 1'b0, 1'b1, 1'b0, 1'b1, 8);
        peek("rej_nop", 1, 32'h0000_0013);
        start(4);
        status("acc4", 1'b0, 1'b1, 1'b1, 1'b0, 0);
        send(prog4b, 4, 0);

        // Reset in the middle of a load
        start(8);
        send(prog8, 3, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        status("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        peek("midrst_nop", 0, 32'h0000_0013);
        start(4);
        send(prog4, 4, 0);
        peek("fresh4_w0", 0, 32'h00A00513);

        // Reload from DONE keeps bytes beyond the new length
        start(8);
        send(prog8, 8, 0);
        start(4);
        status("reload", 1'b0, 1'b1, 1'b1, 1'b0, 0);
        send(prog4b, 4, 0);
        peek("reload_w0", 0, 32'h00100093);
        peek("reload_w1", 1, 32'hFFF9C137);
        peek("reload_wrap", 16, 32'h00100093);
        chk("model_rw0", model_word(16), 32'h00100093);

        // Randomized traffic
        rnd_fa = 1'b1;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) len = $urandom_range(0, 127);
            else len = 4 * $urandom_range(1, MEM_BYTES / 4);
            start(len);
            if (len != 0 && len <= MEM_BYTES && len % 4 == 0) begin
                q = {};
                for (int k = 0; k < len; k++) q.push_back(8'($urandom));
                if ($urandom_range(0, 7) == 0) begin
                    n = $urandom_range(0, len - 1);
                    send(q, n, 2);
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                end else begin
                    send(q, len, $urandom_range(0, 2));
                end
            end
            repeat ($urandom_range(1, 6)) tick();
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-addressed, little-endian instruction memory.
- Accepts a program as a stream of bytes over a valid/ready handshake and writes them into byte-wide storage.
- Serves 32-bit fetch words to the core by word address.
- Holds the core in stall until a complete program has been loaded.

Parameters:
- MEM_BYTES, 64, storage size in bytes; must be a power of two and ≥ 4.
- ADDR_W, 6, log2(MEM_BYTES).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle request to begin a load; sampled in IDLE and DONE only.
- load_len  in  ADDR_W+1  number of bytes to load; sampled on the same cycle as load_start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  program byte; byte k of the stream goes to memory byte address k.
- byte_ready  out  1  loader accepts a byte this cycle.
- load_done  out  1  program loaded; memory may be fetched.
- load_err  out  1  last load_start was rejected.
- cpu_hold  out  1  stall request to the core.
- bytes_written  out  ADDR_W+1  bytes accepted in the current or last load.
- fetch_addr  in  30  word address from the core.
- fetch_data  out  32  instruction word.

Behaviour:
- Reset values: state=IDLE, byte_ready=0, load_done=0, load_err=0, cpu_hold=1, bytes_written=0. Memory contents are not reset.
- Handshake: a byte is accepted on a cycle with byte_valid && byte_ready. byte_ready is a pure function of state; it is 1 only in LOAD.
- States:
  - IDLE: cpu_hold=1.
  - LOAD: byte_ready=1, cpu_hold=1, load_done=0.
  - DONE: load_done=1, cpu_hold=0, byte_ready=0.
- load_start validation (IDLE or DONE):
  - Reject if load_len==0, load_len>MEM_BYTES, or load_len[1:0]!=0.
  - On reject: load_err=1, next state IDLE, cpu_hold=1, load_done=0, memory untouched.
  - On accept: load_err=0, bytes_written=0, next state LOAD.
- LOAD state:
  - On accept: mem[bytes_written] <= byte_data; bytes_written increments.
  - When the accepted byte makes bytes_written == load_len (latched), the next state is DONE. load_done rises the cycle after the final handshake.
  - load_start is ignored during LOAD.
  - There is no timeout; LOAD waits indefinitely for bytes.
- Memory:
  - Byte addresses ≥ latched load_len keep their previous contents.
  - A write is visible on fetch_data the cycle after acceptance.
- Fetch read: combinational, fetch_data = {mem[{a,2'b11}], mem[{a,2'b10}], mem[{a,2'b01}], mem[{a,2'b00}]}.
  - a = fetch_addr[ADDR_W-3:0]; upper address bits are ignored, so addresses wrap.
  - While cpu_hold=1, fetch_data = 32'h00000013 (NOP, addi x0,x0,0) regardless of memory contents.
- Reload from DONE: a valid load_start returns to LOAD. cpu_hold reasserts and load_done drops on the next cycle.
- Reset mid-LOAD: the loader returns to IDLE with reset values. Partially written bytes remain but are masked by the NOP output.
- Simultaneous rst and load_start: rst wins.

Test Plan:
- Reset → cpu_hold=1, load_done=0, byte_ready=0, fetch_data=32'h00000013 for every fetch_addr.
- load_start with load_len=8; bytes B7 40 06 00 37 C1 F9 FF, byte_valid high 8 cycles → load_done=1 one cycle after the 8th handshake, bytes_written=8, cpu_hold=0. Then fetch_addr=0 gives 32'h000640B7; fetch_addr=1 gives 32'hFFF9C137.
- Same stream with byte_valid toggling 1,0,0,1,... and byte_data garbage when invalid → identical memory image and bytes_written=8; only handshaken bytes are written.
- load_start with load_len=6, then 68, then 0 → each gives load_err=1, state IDLE, byte_ready=0, cpu_hold=1. A following load_len=4 is accepted with load_err=0.
- rst asserted after 3 accepted bytes → IDLE, bytes_written=0, cpu_hold=1, NOP fetched. A fresh load of 4 bytes 13 05 A0 00 then gives fetch_addr=0 → 32'h00A00513.
- From DONE after the 8-byte load, reload load_len=4 with 93 00 10 00 → word0=32'h00100093, word1 still 32'hFFF9C137. fetch_addr=16 returns word0 (wrap).
